// File: rtl/dpram_pkg.sv
// Shared definitions for the parametrised dual-port RAM: read-mode encodings,
// controller state type and lane-count helper.
package dpram_pkg;

  localparam int RD_READ_FIRST  = 0;
  localparam int RD_WRITE_FIRST = 1;
  localparam int RD_NO_CHANGE   = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int calc_num_bytes(int data_width, int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/dpram_port_out.sv
// Per-port read path: read-during-write mux, read-data register and an
// optional second pipeline stage that carries dout_valid along with the data.
module dpram_port_out
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_BYTES  = 1,
  parameter int RD_MODE    = RD_READ_FIRST,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  access,
  input  logic                  we,
  input  logic [NUM_BYTES-1:0]  be,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  // Word as it will look after this port's own write lands.
  always_comb begin
    merged = rdata;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (be[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (access && (!we || RD_MODE == RD_READ_FIRST)) begin
      data_q  <= rdata;
      valid_q <= 1'b1;
    end else if (access && RD_MODE == RD_WRITE_FIRST) begin
      data_q  <= merged;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] data_q2;
      logic                  valid_q2;

      // Free-running stage: it follows stage one every cycle, held data included.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q2  <= '0;
          valid_q2 <= 1'b0;
        end else begin
          data_q2  <= data_q;
          valid_q2 <= valid_q;
        end
      end
      assign dout       = data_q2;
      assign dout_valid = valid_q2;
    end else begin : g_no_out_reg
      assign dout       = data_q;
      assign dout_valid = valid_q;
    end
  endgenerate

endmodule

// File: rtl/dual_port_ram_param.sv
// True dual-port RAM shared by two agents: byte-lane writes, port A wins
// overlapping same-address writes, and the array is zeroed after reset.
module dual_port_ram_param
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 6,
  parameter int BYTE_WIDTH     = 8,
  parameter int RD_MODE        = RD_READ_FIRST,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NUM_BYTES     = calc_num_bytes(DATA_WIDTH, BYTE_WIDTH),
  localparam int DEPTH         = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  output logic                  collision,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [NUM_BYTES-1:0]  be_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  dout_valid_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [NUM_BYTES-1:0]  be_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  dout_valid_b
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  clr_we;
  logic                  ready_q;
  logic                  collision_q;

  // Access protocol: en_x is sampled on a rising edge only while ready is
  // high; there is no backpressure, so an enabled access while ready is low
  // is dropped rather than stalled.
  logic acc_a, acc_b, wr_a, wr_b, coll_d;
  assign acc_a  = en_a & ready_q;
  assign acc_b  = en_b & ready_q;
  assign wr_a   = acc_a & we_a;
  assign wr_b   = acc_b & we_b;
  assign coll_d = wr_a & wr_b & (addr_a == addr_b) & (|(be_a & be_b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt         <= '0;
      ready_q     <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= clr_we ? cnt + 1'b1 : cnt;
      ready_q     <= (next_state == ST_RUN);
      collision_q <= coll_d;
    end
  end

  always_comb begin
    next_state = state;
    clr_we     = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt == {ADDR_WIDTH{1'b1}}) next_state = ST_RUN;
      end
      ST_RUN:   next_state = ST_RUN;
      default:  next_state = ST_CLEAR;
    endcase
  end

  // Port A's lanes are assigned last so they override B on overlap.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_b && be_b[i]) mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_a && be_a[i]) mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  assign rdata_a = mem[addr_a];
  assign rdata_b = mem[addr_b];

  dpram_port_out #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .NUM_BYTES  (NUM_BYTES),
    .RD_MODE    (RD_MODE),
    .OUT_REG    (OUT_REG)
  ) u_out_a (
    .clk        (clk),
    .rst        (rst),
    .access     (acc_a),
    .we         (we_a),
    .be         (be_a),
    .din        (din_a),
    .rdata      (rdata_a),
    .dout       (dout_a),
    .dout_valid (dout_valid_a)
  );

  dpram_port_out #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .NUM_BYTES  (NUM_BYTES),
    .RD_MODE    (RD_MODE),
    .OUT_REG    (OUT_REG)
  ) u_out_b (
    .clk        (clk),
    .rst        (rst),
    .access     (acc_b),
    .we         (we_b),
    .be         (be_b),
    .din        (din_b),
    .rdata      (rdata_b),
    .dout       (dout_b),
    .dout_valid (dout_valid_b)
  );

  assign ready     = ready_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench for dual_port_ram_param: three instances (8-bit read-first, 16-bit
// write-first with output register, 16-bit no-change) share one stimulus.
module tb_dual_port_ram_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [1:0]  be_a = '0, be_b = '0;
  logic [5:0]  addr_a = '0, addr_b = '0;
  logic [15:0] din_a = '0, din_b = '0;

  logic [7:0]  d0a, d0b;
  logic [15:0] d1a, d1b, d2a, d2b;
  logic        v0a, v0b, v1a, v1b, v2a, v2b;
  logic        c0, c1, c2, r0, r1, r2;

  dual_port_ram_param u_dut0 (
    .clk(clk), .rst(rst), .ready(r0), .collision(c0),
    .en_a(en_a), .we_a(we_a), .be_a(be_a[0]), .addr_a(addr_a), .din_a(din_a[7:0]),
    .dout_a(d0a), .dout_valid_a(v0a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b[0]), .addr_b(addr_b), .din_b(din_b[7:0]),
    .dout_b(d0b), .dout_valid_b(v0b)
  );

  dual_port_ram_param #(.DATA_WIDTH(16), .RD_MODE(1), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .ready(r1), .collision(c1),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(d1a), .dout_valid_a(v1a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(d1b), .dout_valid_b(v1b)
  );

  dual_port_ram_param #(.DATA_WIDTH(16), .RD_MODE(2), .OUT_REG(0)) u_dut2 (
    .clk(clk), .rst(rst), .ready(r2), .collision(c2),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(d2a), .dout_valid_a(v2a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(d2b), .dout_valid_b(v2b)
  );

  logic [15:0] obs_d [3][2];
  logic        obs_v [3][2];
  logic        obs_c [3];
  logic        obs_r [3];

  always_comb begin
    obs_d[0][0] = {8'h00, d0a}; obs_d[0][1] = {8'h00, d0b};
    obs_d[1][0] = d1a;          obs_d[1][1] = d1b;
    obs_d[2][0] = d2a;          obs_d[2][1] = d2b;
    obs_v[0][0] = v0a; obs_v[0][1] = v0b;
    obs_v[1][0] = v1a; obs_v[1][1] = v1b;
    obs_v[2][0] = v2a; obs_v[2][1] = v2b;
    obs_c[0] = c0; obs_c[1] = c1; obs_c[2] = c2;
    obs_r[0] = r0; obs_r[1] = r1; obs_r[2] = r2;
  end

  typedef struct {
    logic        en_a;
    logic        we_a;
    logic [1:0]  be_a;
    logic [5:0]  addr_a;
    logic [15:0] din_a;
    logic        en_b;
    logic        we_b;
    logic [1:0]  be_b;
    logic [5:0]  addr_b;
    logic [15:0] din_b;
    logic        exp_c8;
    logic        exp_c16;
  } vec_t;

  typedef struct {
    int          due;
    int          dut;
    int          port;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem_m [64];
  logic [15:0] last_d [3][2];
  logic        coll_next [3];
  logic        coll_now [3];
  logic        rdy_exp = 1'b0;
  int          clr_left = 64;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl [18];

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    bit          hit [3][2];
    logic [15:0] hd [3][2];
    exp_t        keep[$];
    for (int d = 0; d < 3; d++) for (int p = 0; p < 2; p++) begin
      hit[d][p] = 1'b0; hd[d][p] = '0;
    end
    foreach (exp_q[i]) begin
      if (exp_q[i].due == cyc) begin
        hit[exp_q[i].dut][exp_q[i].port] = 1'b1;
        hd[exp_q[i].dut][exp_q[i].port]  = exp_q[i].data;
      end else begin
        keep.push_back(exp_q[i]);
      end
    end
    exp_q = keep;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (hit[d][p]) last_d[d][p] = hd[d][p];
        cmp($sformatf("dout_valid dut%0d port%0d", d, p), 16'(obs_v[d][p]), 16'(hit[d][p]));
        cmp($sformatf("dout dut%0d port%0d", d, p), obs_d[d][p], last_d[d][p]);
      end
      cmp($sformatf("collision dut%0d", d), 16'(obs_c[d]), 16'(coll_now[d]));
      cmp($sformatf("ready dut%0d", d), 16'(obs_r[d]), 16'(rdy_exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (clr_left > 0) clr_left--;
    rdy_exp = !rst && (clr_left == 0);
    for (int d = 0; d < 3; d++) begin
      coll_now[d]  = coll_next[d];
      coll_next[d] = 1'b0;
    end
    check_outputs();
  endtask

  task automatic push_port(input int p, input logic we, input logic [1:0] be,
                           input logic [15:0] din, input logic [15:0] old);
    exp_t        e;
    logic [15:0] merged;
    merged = {be[1] ? din[15:8] : old[15:8], be[0] ? din[7:0] : old[7:0]};
    e.port = p;
    e.due = cyc + 1; e.dut = 0; e.data = {8'h00, old[7:0]};
    exp_q.push_back(e);
    e.due = cyc + 2; e.dut = 1; e.data = we ? merged : old;
    exp_q.push_back(e);
    if (!we) begin
      e.due = cyc + 1; e.dut = 2; e.data = old;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input vec_t v);
    logic [15:0] old_a, old_b;
    logic        wa, wb;
    en_a = v.en_a; we_a = v.we_a; be_a = v.be_a; addr_a = v.addr_a; din_a = v.din_a;
    en_b = v.en_b; we_b = v.we_b; be_b = v.be_b; addr_b = v.addr_b; din_b = v.din_b;
    if (rdy_exp) begin
      old_a = mem_m[v.addr_a];
      old_b = mem_m[v.addr_b];
      if (v.en_a) push_port(0, v.we_a, v.be_a, v.din_a, old_a);
      if (v.en_b) push_port(1, v.we_b, v.be_b, v.din_b, old_b);
      wa = v.en_a & v.we_a;
      wb = v.en_b & v.we_b;
      coll_next[0] = wa & wb & (v.addr_a == v.addr_b) & v.be_a[0] & v.be_b[0];
      coll_next[1] = wa & wb & (v.addr_a == v.addr_b) & (|(v.be_a & v.be_b));
      coll_next[2] = coll_next[1];
      for (int i = 0; i < 2; i++) begin
        if (wb && v.be_b[i]) mem_m[v.addr_b][i*8 +: 8] = v.din_b[i*8 +: 8];
      end
      for (int i = 0; i < 2; i++) begin
        if (wa && v.be_a[i]) mem_m[v.addr_a][i*8 +: 8] = v.din_a[i*8 +: 8];
      end
    end
    tick();
  endtask

  function automatic vec_t idle_v();
    vec_t v;
    v = '{default: 0};
    return v;
  endfunction

  function automatic vec_t rd2(input logic [5:0] aa, input logic [5:0] ab);
    vec_t v;
    v = idle_v();
    v.en_a = 1'b1; v.addr_a = aa;
    v.en_b = 1'b1; v.addr_b = ab;
    return v;
  endfunction

  function automatic vec_t rand_v(input int amax);
    vec_t v;
    v = idle_v();
    v.en_a = 1'($urandom_range(0, 1));   v.we_a = 1'($urandom_range(0, 1));
    v.be_a = 2'($urandom_range(0, 3));   v.addr_a = 6'($urandom_range(0, amax));
    v.din_a = 16'($urandom_range(0, 65535));
    v.en_b = 1'($urandom_range(0, 1));   v.we_b = 1'($urandom_range(0, 1));
    v.be_b = 2'($urandom_range(0, 3));   v.addr_b = 6'($urandom_range(0, amax));
    v.din_b = 16'($urandom_range(0, 65535));
    return v;
  endfunction

  // Asynchronous assertion: outputs must drop before the next clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        cmp($sformatf("async dout dut%0d port%0d", d, p), obs_d[d][p], 16'h0000);
        cmp($sformatf("async valid dut%0d port%0d", d, p), 16'(obs_v[d][p]), 16'h0000);
        last_d[d][p] = '0;
      end
      cmp($sformatf("async collision dut%0d", d), 16'(obs_c[d]), 16'h0000);
      cmp($sformatf("async ready dut%0d", d), 16'(obs_r[d]), 16'h0000);
      coll_next[d] = 1'b0;
    end
    exp_q.delete();
    rdy_exp  = 1'b0;
    clr_left = 64;
    drive(idle_v());
    drive(idle_v());
    rst      = 1'b0;
    clr_left = 64;
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 64; a++) begin
      drive(rd2(6'(a), 6'(63 - a)));
      cmp("model cleared", mem_m[a], 16'h0000);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      coll_next[d] = 1'b0;
      coll_now[d]  = 1'b0;
      for (int p = 0; p < 2; p++) last_d[d][p] = '0;
    end
    for (int a = 0; a < 64; a++) mem_m[a] = '0;

    tbl = '{
      '{1'b1, 1'b1, 2'b11, 6'd3,  16'h1234, 1'b0, 1'b0, 2'b00, 6'd0,  16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 2'b01, 6'd3,  16'hABCD, 1'b1, 1'b0, 2'b00, 6'd3,  16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b0, 2'b00, 6'd3,  16'h0000, 1'b0, 1'b0, 2'b00, 6'd0,  16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 2'b11, 6'd10, 16'h005C, 1'b0, 1'b0, 2'b00, 6'd0,  16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 2'b11, 6'd5,  16'h0011, 1'b1, 1'b0, 2'b00, 6'd10, 16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 2'b11, 6'd5,  16'h0022, 1'b1, 1'b0, 2'b00, 6'd5,  16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b0, 2'b00, 6'd5,  16'h0000, 1'b0, 1'b0, 2'b00, 6'd0,  16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 2'b11, 6'd7,  16'hAAAA, 1'b1, 1'b1, 2'b10, 6'd7,  16'hBBBB, 1'b0, 1'b1},
      '{1'b1, 1'b0, 2'b00, 6'd7,  16'h0000, 1'b0, 1'b0, 2'b00, 6'd0,  16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 2'b01, 6'd7,  16'hAAAA, 1'b1, 1'b1, 2'b10, 6'd7,  16'hBBBB, 1'b0, 1'b0},
      '{1'b1, 1'b0, 2'b00, 6'd7,  16'h0000, 1'b1, 1'b0, 2'b00, 6'd7,  16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 2'b01, 6'd9,  16'h1111, 1'b1, 1'b1, 2'b11, 6'd9,  16'h2222, 1'b1, 1'b1},
      '{1'b0, 1'b0, 2'b00, 6'd0,  16'h0000, 1'b1, 1'b0, 2'b00, 6'd9,  16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 2'b00, 6'd9,  16'hFFFF, 1'b1, 1'b0, 2'b00, 6'd9,  16'h0000, 1'b0, 1'b0},
      '{1'b0, 1'b0, 2'b00, 6'd0,  16'h0000, 1'b0, 1'b0, 2'b00, 6'd0,  16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b0, 2'b00, 6'd9,  16'h0000, 1'b1, 1'b0, 2'b00, 6'd9,  16'h0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 2'b11, 6'd1,  16'h3333, 1'b1, 1'b1, 2'b11, 6'd2,  16'h4444, 1'b0, 1'b0},
      '{1'b1, 1'b0, 2'b00, 6'd1,  16'h0000, 1'b1, 1'b0, 2'b00, 6'd2,  16'h0000, 1'b0, 1'b0}
    };

    // Power-on reset and first clear; accesses during the clear must vanish.
    drive(idle_v());
    drive(idle_v());
    rst      = 1'b0;
    clr_left = 64;
    repeat (64) drive(rand_v(63));

    // Fill with 0xAA, reset, and confirm the clear wipes it.
    for (int a = 0; a < 64; a++) begin
      vec_t v;
      v = idle_v();
      v.en_a = 1'b1; v.we_a = 1'b1; v.be_a = 2'b11; v.addr_a = 6'(a); v.din_a = 16'hAAAA;
      drive(v);
    end
    do_reset();
    for (int a = 0; a < 64; a++) mem_m[a] = '0;
    repeat (64) drive(rand_v(7));
    read_all_zero();

    // Directed vectors with tabulated collision expectations.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i]);
      cmp($sformatf("tbl%0d collision8", i), 16'(c0), 16'(tbl[i].exp_c8));
      cmp($sformatf("tbl%0d collision16", i), 16'(c1), 16'(tbl[i].exp_c16));
    end
    repeat (3) drive(idle_v());
    cmp("mem7 merged", mem_m[7], 16'hBBAA);
    cmp("mem9 arbitrated", mem_m[9], 16'h2211);

    // Dense random traffic on a few addresses to provoke collisions.
    repeat (200) drive(rand_v(7));
    drive(rd2(6'd3, 6'd5));

    // Reset mid-clear restarts the clear from address 0.
    do_reset();
    for (int a = 0; a < 64; a++) mem_m[a] = '0;
    repeat (20) drive(idle_v());
    do_reset();
    repeat (64) drive(idle_v());
    read_all_zero();

    repeat (4) drive(idle_v());
    cmp("scoreboard drained", 16'(exp_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
- Parametrised true dual-port synchronous RAM. Generalises the existing 8x64 dual-port memory with:
  - configurable width and depth
  - per-byte write enables
  - selectable read-during-write mode
  - optional output register
  - deterministic write-write collision arbitration
  - post-reset memory-clear sequencer
- Used as the shared scratch/buffer memory between two independent agents on one clock domain.

Parameters:
- DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per byte-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- RD_MODE, 0, same-port read-during-write behaviour: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1, 1 zeroes the whole array after reset release.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- ready  out  1  high when the array accepts accesses
- collision  out  1  one-cycle pulse on a same-address write-write collision
- en_a  in  1  port A access enable
- we_a  in  1  port A write (1) / read (0)
- be_a  in  NUM_BYTES  port A byte write enables
- addr_a  in  ADDR_WIDTH  port A address
- din_a  in  DATA_WIDTH  port A write data
- dout_a  out  DATA_WIDTH  port A read data
- dout_valid_a  out  1  port A read-data qualifier
- en_b, we_b, be_b, addr_b, din_b, dout_b, dout_valid_b: same as port A, for port B

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- While rst is high:
  - dout_a/b = 0, dout_valid_a/b = 0, collision = 0, ready = 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET = 1, else to RUN.
  - Clear counter = 0.
  - Array contents are not reset asynchronously.
- FSM states are CLEAR and RUN.
  - CLEAR: writes 0 to address cnt each cycle, then cnt+1. After the write to DEPTH-1, goes to RUN; ready rises on the following cycle. CLEAR lasts exactly DEPTH cycles after rst deassertion.
  - During CLEAR, all en_a/en_b are ignored: no writes, dout_valid stays 0, dout holds.
  - rst asserted mid-CLEAR restarts the clear from address 0.
  - RUN: terminal state until rst.
- Port access, in RUN with en = 1:
  - Write: for each byte i with be[i] = 1, mem[addr] byte i <= din byte i. be = 0 with we = 1 is a no-op write but still counts as an access for RD_MODE.
  - Read: dout <= mem[addr] at the next edge (OUT_REG = 0) or the edge after (OUT_REG = 1).
  - dout_valid is a pulse aligned with dout.
- Same-port read-during-write (we = 1):
  - READ_FIRST: dout = old word, dout_valid = 1.
  - WRITE_FIRST: dout = merged new word (enabled bytes new, others old), dout_valid = 1.
  - NO_CHANGE: dout holds, dout_valid = 0.
- en = 0: dout holds its value; dout_valid = 0.
- Cross-port read/write to the same address in the same cycle:
  - The reader always gets the old word, regardless of RD_MODE.
  - collision is not asserted.
- Both ports write the same address in the same cycle:
  - Overlapping enabled bytes take port A data.
  - Bytes enabled only on B take B data.
  - collision = 1 for one cycle (aligned with the write edge, registered) only if the byte enables overlap.
- Both ports read the same address: both return the word, no collision.
- OUT_REG = 1: the second register stage also resets to 0. dout_valid is delayed with the data; the pipeline keeps moving even when en drops.
- Address wrap: addresses are ADDR_WIDTH bits, so no out-of-range case exists.

Decomposition:
- Shared package dpram_pkg:
  - RD_MODE encodings: RD_READ_FIRST = 0, RD_WRITE_FIRST = 1, RD_NO_CHANGE = 2.
  - FSM state type {ST_CLEAR, ST_RUN}.
  - Function computing NUM_BYTES.
- One natural sub-module, dpram_port_out: per-port read-mode mux plus optional output register and dout_valid pipeline, instantiated twice.
- Array, arbitration and clear FSM stay in the top level.

Test Plan:
- Clear sequence (defaults 8/6, CLEAR_ON_RESET = 1):
  - Write 0xAA to all addresses, pulse rst -> ready low for exactly 64 cycles after release, then high.
  - Reads of addresses 0, 31, 63 return 0x00; accesses issued during CLEAR are ignored.
- Basic latency:
  - Port A writes 0x5C @ addr 10; port B reads addr 10 next cycle -> dout_b = 0x5C one cycle later with dout_valid_b = 1.
  - Repeat with OUT_REG = 1 -> data arrives two cycles later.
- Byte enables (DATA_WIDTH = 16):
  - mem[3] = 0x1234; A writes 0xABCD with be_a = 2'b01 -> read returns 0x12CD.
- Read-during-write modes (mem[5] = 0x11, A writes 0x22 @ 5):
  - RD_MODE 0 -> dout_a = 0x11.
  - RD_MODE 1 -> dout_a = 0x22.
  - RD_MODE 2 -> dout_a holds its previous value, dout_valid_a = 0.
  - In all modes, a simultaneous B read of addr 5 returns 0x11.
- Collision (DATA_WIDTH = 16):
  - Same cycle: A writes 0xAAAA with be 2'b11 @ 7; B writes 0xBBBB with be 2'b10 @ 7.
  - Result: mem[7] = 0xAAAA, collision pulses exactly one cycle.
  - With be_a = 2'b01 instead: mem[7] = 0xBBAA, no collision pulse.
- Reset mid-operation:
  - Assert rst at clear count 20 -> outputs go to 0 immediately (asynchronously).
  - After release, the clear restarts: ready rises 64 cycles later and mem[0..63] = 0.
